seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring divider that performs the inverse of the team's combinational array multipliers.
- Takes a 2W-bit unsigned dividend and a W-bit divisor. Returns a 2W-bit quotient and a W-bit remainder using one quotient bit per clock.
- Checks multiplier results in self-test datapaths: dividing (x*y) by y must return x with remainder 0.
- Uses valid/ready handshakes on both input and output.

Parameters:
- W, 4, divisor and remainder width. Dividend and quotient are 2W bits wide. Legal range is 2..32.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept operands
- dividend  in  2W  numerator
- divisor  in  W  denominator
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- quotient  out  2W  dividend / divisor
- remainder  out  W  dividend mod divisor
- div_by_zero  out  1  divisor was 0 for this result

Behaviour:
- The clock is clk. Reset is rst_n, asynchronous and active-low, with one clock domain only.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, CALC, DONE.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- IDLE, on in_valid=1:
  - Both operands are captured on that edge (the accept edge, E0).
  - If divisor==0: go to DONE. quotient=all ones, remainder=dividend[W-1:0], div_by_zero=1. Latency is 1 cycle.
  - Otherwise: go to CALC. Partial remainder (W+1 bits)=0, shift register=dividend, counter=2W-1, div_by_zero=0.
- CALC, each edge:
  - Shift {partial remainder, shift register} left by 1.
  - Trial = shifted partial remainder - divisor, computed at W+1 bits.
  - If trial is non-negative, take trial and set quotient LSB=1. Otherwise restore and set quotient LSB=0.
  - Decrement the counter.
  - On the edge where counter==0, transition to DONE with final quotient and remainder registered.
  - Total latency is 2W clock edges from E0 to out_valid=1 (8 for W=4).
- DONE:
  - Outputs stay stable while out_valid=1 && out_ready=0 (backpressure). This holds indefinitely.
  - On out_ready=1, return to IDLE on that edge; out_valid drops and in_ready rises.
  - A new operand is not accepted on the same edge as result release. Minimum issue interval is 2W+2 cycles, or 3 for divide-by-zero.
- in_valid is ignored outside IDLE. Operand inputs may change freely after E0.
- Invariant for any nonzero divisor: quotient*divisor + remainder == dividend, with remainder < divisor.
- Reset asserted mid-CALC or in DONE aborts immediately to reset values; the partial result is discarded.
- Remainder always fits in W bits, because partial remainder < divisor after each step.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - Division runs on magnitudes with the same latency. Quotient is negated if the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Quotient is the low 2W bits of the true result, so -2^(2W-1) / -1 wraps to -2^(2W-1).
  - Divide-by-zero behaves as in the unsigned case.
- Undefined: all operands are unsigned, and the sign logic is absent.

Test Plan:
- W=4, dividend=200, divisor=7, out_ready=1 -> out_valid exactly 8 cycles after accept; quotient=0x1C, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=0xFF, remainder=0. Also dividend=0x69 (15*7), divisor=7 -> quotient=15, remainder=0.
- dividend=5, divisor=0 -> out_valid 1 cycle after accept; quotient=0xFF, remainder=5, div_by_zero=1.
- Backpressure: out_ready=0 for 10 cycles after result -> outputs constant, in_ready=0, extra in_valid ignored. out_ready=1 -> IDLE next edge, in_ready=1.
- rst_n low at CALC cycle 3, then high, then a new op 100/9 -> all outputs at reset values during reset; result quotient=11, remainder=1, with no residue from the aborted op.
- With SEQ_DIVIDER_SIGNED_EN: dividend=-100 (0x9C), divisor=7 -> quotient=0xF2 (-14), remainder=0xE (-2). dividend=0x80, divisor=0xF (-1) -> quotient=0x80.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
//
// Divides a 2W-bit dividend by a W-bit divisor, producing a 2W-bit quotient
// and a W-bit remainder. It is the inverse of the combinational array
// multipliers, so (x*y)/y must return x with remainder 0.
//
// Ports:
//   clk          in   1    rising-edge clock
//   rst_n        in   1    asynchronous active-low reset
//   in_valid     in   1    operand pair presented
//   in_ready     out  1    high only in IDLE
//   dividend     in   2W   numerator
//   divisor      in   W    denominator
//   out_valid    out  1    high only in DONE, result held until out_ready
//   out_ready    in   1    consumer accepts the result
//   quotient     out  2W   dividend / divisor (all ones on divide-by-zero)
//   remainder    out  W    dividend mod divisor (dividend[W-1:0] on divide-by-zero)
//   div_by_zero  out  1    divisor was 0 for this result
//
// Optional feature, macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands.
// The array divides magnitudes with the same latency. The quotient is negated
// when the operand signs differ, and the remainder takes the dividend's sign.
// The quotient is truncated to 2W bits, so -2^(2W-1) / -1 wraps.
module seq_divider #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   dividend,
   input  logic [W-1:0]     divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   quotient,
   output logic [W-1:0]     remainder,
   output logic             div_by_zero
);

   localparam int DW = 2 * W;
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // The partial remainder stays below the divisor after every step, so W bits
   // hold it. Only the shifted value needs the extra (W+1)th bit.
   logic [W-1:0]  prem_q, prem_d;
   // The dividend shifts out at the top while quotient bits shift in at the
   // bottom. After 2W steps, this register holds the quotient.
   logic [DW-1:0] sr_q, sr_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic [W:0]    prem_sh;
   logic [W:0]    trial;
   logic          qbit;
   logic [W-1:0]  prem_next;
   logic [DW-1:0] sr_next;
   logic [DW-1:0] op_dividend;
   logic [W-1:0]  op_divisor;
   logic [DW-1:0] quot_fin;
   logic [W-1:0]  rem_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic qneg_q, qneg_d;
   logic rneg_q, rneg_d;

   // Magnitude of a negative value. -2^(N-1) maps to 2^(N-1), which still
   // fits when it is read as unsigned.
   function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] v);
      return v[DW-1] ? -v : v;
   endfunction

   function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
      return v[W-1] ? -v : v;
   endfunction
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prem_d      = prem_q;
      sr_d        = sr_q;
      dvs_d       = dvs_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      op_dividend = dividend;
      op_divisor  = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      op_dividend = abs_dw(dividend);
      op_divisor  = abs_w(divisor);
`endif

      // One restoring step. The trial is negative exactly when the shifted
      // remainder is below the divisor. In that case the shifted value is kept.
      prem_sh   = {prem_q, sr_q[DW-1]};
      trial     = prem_sh - {1'b0, dvs_q};
      qbit      = ~trial[W];
      prem_next = qbit ? trial[W-1:0] : prem_sh[W-1:0];
      sr_next   = {sr_q[DW-2:0], qbit};

      quot_fin  = sr_next;
      rem_fin   = prem_next;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (qneg_q) quot_fin = -sr_next;
      if (rneg_q) rem_fin  = -prem_next;
`endif

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = dividend[W-1:0];
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  prem_d  = '0;
                  sr_d    = op_dividend;
                  dvs_d   = op_divisor;
                  cnt_d   = CW'(DW - 1);
                  dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  qneg_d  = dividend[DW-1] ^ divisor[W-1];
                  rneg_d  = dividend[DW-1];
`endif
               end
            end
         end
         CALC: begin
            prem_d = prem_next;
            sr_d   = sr_next;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               quot_d  = quot_fin;
               rem_d   = rem_fin;
            end
         end
         DONE: begin
            // Release only. The next operand waits for IDLE.
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         sr_q    <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         sr_q    <= sr_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed bench for seq_divider, W=4.
// A behavioural model based on plain integer division supplies every
// expected result.
module tb_seq_divider;

   localparam int W   = 4;
   localparam int DW  = 2 * W;
   localparam int LAT = 2 * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [W-1:0]  divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_divider #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   // Reference: integer division (truncating toward zero for the signed build).
   function automatic void model(input logic [DW-1:0] dd, input logic [W-1:0] dv,
                                 output logic [DW-1:0] q, output logic [W-1:0] r,
                                 output logic z);
      longint a, b;
      if (dv == '0) begin
         q = '1;
         r = dd[W-1:0];
         z = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         a = longint'($signed(dd));
         b = longint'($signed(dv));
`else
         a = longint'(dd);
         b = longint'(dv);
`endif
         q = DW'(a / b);
         r = W'(a % b);
         z = 1'b0;
      end
   endfunction

   // Present operands from IDLE and return #1 after the accept edge.
   task automatic start_op(input logic [DW-1:0] dd, input logic [W-1:0] dv);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      dividend = dd;
      divisor  = dv;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      n_checks++;
      if (guard >= 100) begin
         n_fail++;
         $display("FAIL start_op_timeout: in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = DW'($urandom);
      divisor  = W'($urandom);
   endtask

   // Count edges after the accept edge until out_valid is seen.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks += 5;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
      if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %h, required 0", quotient); end
      if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %h, required 0", remainder); end
      if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %0b, required 0", div_by_zero); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [DW-1:0] dds [3];
      logic [W-1:0]  dvs [3];
      logic [DW-1:0] eq;
      logic [W-1:0]  er;
      logic          ez;
      int            lat;
      dds[0] = 8'd200; dvs[0] = 4'd7;
      dds[1] = 8'd255; dvs[1] = 4'd1;
      dds[2] = 8'h69;  dvs[2] = 4'd7;
      for (int i = 0; i < 3; i++) begin
         model(dds[i], dvs[i], eq, er, ez);
         start_op(dds[i], dvs[i]);
         wait_done(lat);
         n_checks += 4;
         if (lat != LAT) begin n_fail++; $display("FAIL directed%0d_latency: got %0d, required %0d", i, lat, LAT); end
         if (quotient !== eq) begin n_fail++; $display("FAIL directed%0d_quotient: got %h, required %h", i, quotient, eq); end
         if (remainder !== er) begin n_fail++; $display("FAIL directed%0d_remainder: got %h, required %h", i, remainder, er); end
         if (div_by_zero !== ez) begin n_fail++; $display("FAIL directed%0d_dbz: got %0b, required %0b", i, div_by_zero, ez); end
         release_result();
      end
   endtask

   task automatic test_div_zero();
      int lat;
      start_op(8'd5, 4'd0);
      wait_done(lat);
      n_checks += 4;
      if (lat != 0) begin n_fail++; $display("FAIL dbz_latency: extra edges %0d, required 0", lat); end
      if (quotient !== 8'hFF) begin n_fail++; $display("FAIL dbz_quotient: got %h, required ff", quotient); end
      if (remainder !== 4'd5) begin n_fail++; $display("FAIL dbz_remainder: got %h, required 5", remainder); end
      if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %0b, required 1", div_by_zero); end
      release_result();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] eq;
      logic [W-1:0]  er;
      logic          ez;
      int            lat;
      model(8'd200, 4'd7, eq, er, ez);
      start_op(8'd200, 4'd7);
      wait_done(lat);
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         dividend = DW'($urandom);
         divisor  = W'($urandom_range(1, 15));
         @(posedge clk); #1;
         n_checks += 3;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handshake%0d: out_valid=%0b in_ready=%0b, required 1 0", c, out_valid, in_ready);
         end
         if (quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got q=%h r=%h, required q=%h r=%h", c, quotient, remainder, eq, er);
         end
         if (div_by_zero !== ez) begin n_fail++; $display("FAIL bp_dbz%0d: got %0b, required %0b", c, div_by_zero, ez); end
      end
      // in_valid is still high on the release edge and must not be taken.
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %0b, required 0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %0b, required 1", in_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept: in_ready=%0b, required 1", in_ready); end
   endtask

   task automatic test_reset_abort();
      logic [DW-1:0] eq;
      logic [W-1:0]  er;
      logic          ez;
      int            lat;
      start_op(8'd200, 4'd3);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks += 5;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %0b, required 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %0b, required 0", out_valid); end
      if (quotient !== '0) begin n_fail++; $display("FAIL abort_quotient: got %h, required 0", quotient); end
      if (remainder !== '0) begin n_fail++; $display("FAIL abort_remainder: got %h, required 0", remainder); end
      if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dbz: got %0b, required 0", div_by_zero); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model(8'd100, 4'd9, eq, er, ez);
      start_op(8'd100, 4'd9);
      wait_done(lat);
      n_checks += 3;
      if (lat != LAT) begin n_fail++; $display("FAIL abort_new_latency: got %0d, required %0d", lat, LAT); end
      if (quotient !== eq || remainder !== er) begin
         n_fail++;
         $display("FAIL abort_new_result: got q=%h r=%h, required q=%h r=%h", quotient, remainder, eq, er);
      end
      if (div_by_zero !== ez) begin n_fail++; $display("FAIL abort_new_dbz: got %0b, required %0b", div_by_zero, ez); end
      release_result();
   endtask

   task automatic test_random();
      logic [DW-1:0] dd, eq;
      logic [W-1:0]  dv, er;
      logic          ez;
      int            lat;
      for (int i = 0; i < 40; i++) begin
         dd = DW'($urandom);
         dv = (i % 8 == 7) ? '0 : W'($urandom);
         model(dd, dv, eq, er, ez);
         start_op(dd, dv);
         wait_done(lat);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         n_checks += 3;
         if (lat != (ez ? 0 : LAT)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d, required %0d", i, lat, ez ? 0 : LAT); end
         if (quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL rand%0d_result %h/%h: got q=%h r=%h, required q=%h r=%h", i, dd, dv, quotient, remainder, eq, er);
         end
         if (div_by_zero !== ez) begin n_fail++; $display("FAIL rand%0d_dbz: got %0b, required %0b", i, div_by_zero, ez); end
`ifndef SEQ_DIVIDER_SIGNED_EN
         if (dv != '0) begin
            n_checks++;
            if (int'(quotient) * int'(dv) + int'(remainder) != int'(dd) || remainder >= dv) begin
               n_fail++;
               $display("FAIL rand%0d_invariant: q=%h r=%h, required q*%h+r=%h with r<divisor", i, quotient, remainder, dv, dd);
            end
         end
`endif
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] eq;
      logic [W-1:0]  er;
      logic          ez;
      int            accepts [$];
      model(8'd200, 4'd7, eq, er, ez);
      in_valid  = 1'b1;
      dividend  = 8'd200;
      divisor   = 4'd7;
      out_ready = 1'b1;
      for (int c = 0; c < 35; c++) begin
         if (in_ready) accepts.push_back(c);
         if (out_valid) begin
            n_checks++;
            if (quotient !== eq || remainder !== er) begin
               n_fail++;
               $display("FAIL b2b_result@%0d: got q=%h r=%h, required q=%h r=%h", c, quotient, remainder, eq, er);
            end
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (accepts.size() != 4) begin n_fail++; $display("FAIL b2b_accept_count: got %0d, required 4", accepts.size()); end
      for (int k = 1; k < accepts.size(); k++) begin
         n_checks++;
         if (accepts[k] - accepts[k-1] != LAT + 2) begin
            n_fail++;
            $display("FAIL b2b_interval%0d: got %0d, required %0d", k, accepts[k] - accepts[k-1], LAT + 2);
         end
      end
      repeat (LAT + 2) @(posedge clk);
      #1;
   endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
   task automatic test_signed();
      int lat;
      start_op(8'h9C, 4'd7);
      wait_done(lat);
      n_checks += 2;
      if (quotient !== 8'hF2) begin n_fail++; $display("FAIL signed_neg_quotient: got %h, required f2", quotient); end
      if (remainder !== 4'hE) begin n_fail++; $display("FAIL signed_neg_remainder: got %h, required e", remainder); end
      release_result();
      start_op(8'h80, 4'hF);
      wait_done(lat);
      n_checks += 2;
      if (quotient !== 8'h80) begin n_fail++; $display("FAIL signed_wrap_quotient: got %h, required 80", quotient); end
      if (remainder !== 4'h0) begin n_fail++; $display("FAIL signed_wrap_remainder: got %h, required 0", remainder); end
      release_result();
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      test_reset();
      test_directed();
      test_div_zero();
      test_backpressure();
      test_reset_abort();
      test_random();
      test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
